// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch, present-and-hold handshake,
// conditional branch target resolution on accept, sticky misaligned-target error.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        zero,
    input  logic        negative,
    input  logic [2:0]  funct3,
    input  logic [12:0] branch_offset,
    output logic        fetch_err
);

    typedef enum logic [1:0] {START, FETCH, HOLD, ERR} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        cond;
    logic        taken;
    logic [31:0] offset_ext;
    logic [31:0] target;

    // Branch resolution is only consumed on the accept edge, so the
    // flags are effectively sampled there and nowhere else.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = zero;
            3'b001:  cond = !zero;
            3'b100:  cond = negative;
            3'b101:  cond = !negative;
            default: cond = 1'b0;
        endcase
        taken      = branch & cond;
        offset_ext = {{19{branch_offset[12]}}, branch_offset} & ~32'd1;
        target     = taken ? (instr_pc + offset_ext) : (instr_pc + 32'd4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= START;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= 32'd0;
            instr_pc    <= RESET_PC;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                START: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                FETCH: begin
                    if (imem_valid) begin
                        instr_out   <= imem_rdata;
                        instr_pc    <= fetch_pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (target[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= ERR;
                        end else begin
                            fetch_pc  <= target;
                            imem_req  <= 1'b1;
                            imem_addr <= target;
                            state     <= FETCH;
                        end
                    end
                end
                default: begin
                    // ERR holds until reset
                    state <= ERR;
                end
            endcase
        end
    end

endmodule
